// File: rtl/pushdown_stack.sv
// -----------------------------------------------------------------------------
// pushdown_stack
//
// Synchronous LIFO of WIDTH-bit words, DEPTH entries deep. One operation is
// performed per rising clock edge when Enable is high: a push (PushPop=0) or
// a pop (PushPop=1). A push while Full and a pop while Empty are ignored. The
// popped word is registered on O and held until the next successful pop.
//
// Optional feature macro: PUSHDOWN_STACK_ERR_EN
//   When defined, adds the registered output Error. It pulses high for one
//   cycle after an enabled push while Full or an enabled pop while Empty.
//
// Ports:
//   CLK      in   1      clock, rising edge active
//   Reset    in   1      asynchronous active-low reset
//   Enable   in   1      operation enable; 0 holds all state
//   PushPop  in   1      0 = push, 1 = pop
//   I        in   WIDTH  data to push
//   O        out  WIDTH  registered data from the most recent pop
//   Empty    out  1      stack holds no entries
//   Full     out  1      stack holds DEPTH entries
//   Error    out  1      (PUSHDOWN_STACK_ERR_EN only) illegal-operation flag
// -----------------------------------------------------------------------------
module pushdown_stack #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             Enable,
  input  logic             PushPop,
  input  logic [WIDTH-1:0] I,
  output logic [WIDTH-1:0] O,
  output logic             Empty,
`ifdef PUSHDOWN_STACK_ERR_EN
  output logic             Full,
  output logic             Error
`else
  output logic             Full
`endif
);

  // Index width addresses mem; pointer width also represents the value DEPTH.
  localparam int AW  = $clog2(DEPTH);
  localparam int SPW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [SPW-1:0]   sp_q;
  logic [SPW-1:0]   sp_d;
  logic [WIDTH-1:0] o_q;
  logic [WIDTH-1:0] o_d;
  logic             wr_en_s;
  logic [AW-1:0]    wr_idx_s;
  logic [AW-1:0]    rd_idx_s;
  logic             empty_s;
  logic             full_s;
`ifdef PUSHDOWN_STACK_ERR_EN
  logic             err_q;
  logic             err_d;
`endif

  // Status flags decoded from the registered pointer.
  assign empty_s = (sp_q == {SPW{1'b0}});
  assign full_s  = (sp_q == SPW'(DEPTH));

  // Push writes at sp (always < DEPTH when not full); pop reads at sp-1
  // (always >= 0 when not empty), so truncation to AW bits is safe.
  assign wr_idx_s = sp_q[AW-1:0];
  assign rd_idx_s = AW'(sp_q - SPW'(1));

  // Next-state decode for pointer, output data and error flag.
  always_comb begin
    sp_d    = sp_q;
    o_d     = o_q;
    wr_en_s = 1'b0;
`ifdef PUSHDOWN_STACK_ERR_EN
    err_d   = 1'b0;
`endif
    if (Enable) begin
      if (!PushPop) begin
        if (!full_s) begin
          wr_en_s = 1'b1;
          sp_d    = sp_q + SPW'(1);
        end else begin
`ifdef PUSHDOWN_STACK_ERR_EN
          err_d = 1'b1;
`else
          sp_d  = sp_q;
`endif
        end
      end else begin
        if (!empty_s) begin
          o_d  = mem_q[rd_idx_s];
          sp_d = sp_q - SPW'(1);
        end else begin
`ifdef PUSHDOWN_STACK_ERR_EN
          err_d = 1'b1;
`else
          sp_d  = sp_q;
`endif
        end
      end
    end else begin
      sp_d = sp_q;
    end
  end

  // Pointer, output and error registers with asynchronous reset.
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      sp_q  <= {SPW{1'b0}};
      o_q   <= {WIDTH{1'b0}};
`ifdef PUSHDOWN_STACK_ERR_EN
      err_q <= 1'b0;
`endif
    end else begin
      sp_q  <= sp_d;
      o_q   <= o_d;
`ifdef PUSHDOWN_STACK_ERR_EN
      err_q <= err_d;
`endif
    end
  end

  // Storage array; contents are not cleared by reset, but a write is
  // suppressed while Reset is asserted so the reset cycle has no effect.
  always_ff @(posedge CLK) begin
    if (wr_en_s && Reset) begin
      mem_q[wr_idx_s] <= I;
    end
  end

  assign O     = o_q;
  assign Empty = empty_s;
  assign Full  = full_s;
`ifdef PUSHDOWN_STACK_ERR_EN
  assign Error = err_q;
`endif

endmodule

// File: tb/tb_pushdown_stack.sv
// -----------------------------------------------------------------------------
// tb_pushdown_stack
//
// Self-checking bench for pushdown_stack (WIDTH=8, DEPTH=8). A queue-based
// LIFO model predicts O, Empty, Full (and Error when PUSHDOWN_STACK_ERR_EN is
// defined). Directed steps cover reset, fill/overflow, drain/underflow,
// enable hold and an interleaved sequence, followed by randomized operations.
// -----------------------------------------------------------------------------
module tb_pushdown_stack;

  localparam int WIDTH = 8;
  localparam int DEPTH = 8;

  logic             CLK;
  logic             Reset;
  logic             Enable;
  logic             PushPop;
  logic [WIDTH-1:0] I;
  logic [WIDTH-1:0] O;
  logic             Empty;
  logic             Full;
`ifdef PUSHDOWN_STACK_ERR_EN
  logic             Error;
`endif

  pushdown_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .CLK     (CLK),
    .Reset   (Reset),
    .Enable  (Enable),
    .PushPop (PushPop),
    .I       (I),
    .O       (O),
    .Empty   (Empty),
`ifdef PUSHDOWN_STACK_ERR_EN
    .Full    (Full),
    .Error   (Error)
`else
    .Full    (Full)
`endif
  );

  // Reference model: a plain LIFO queue plus the last popped value.
  logic [WIDTH-1:0] model_q [$];
  logic [WIDTH-1:0] model_o;
  logic             model_err;

  int pass_cnt  = 0;
  int total_cnt = 0;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt = total_cnt + 1;
    assert (obs === exp) pass_cnt = pass_cnt + 1;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic check_all(input string tag);
    check({tag, ".O"},     32'(O),     32'(model_o));
    check({tag, ".Empty"}, 32'(Empty), 32'(model_q.size() == 0));
    check({tag, ".Full"},  32'(Full),  32'(model_q.size() == DEPTH));
`ifdef PUSHDOWN_STACK_ERR_EN
    check({tag, ".Error"}, 32'(Error), 32'(model_err));
`endif
  endtask

  // Apply one operation for one clock edge, advance the model, then check.
  task automatic do_op(input logic en, input logic pp, input logic [WIDTH-1:0] d, input string tag);
    Enable  = en;
    PushPop = pp;
    I       = d;
    @(posedge CLK);
    #1;
    model_err = 1'b0;
    if (en) begin
      if (!pp) begin
        if (model_q.size() < DEPTH) model_q.push_back(d);
        else model_err = 1'b1;
      end else begin
        if (model_q.size() > 0) model_o = model_q.pop_back();
        else model_err = 1'b1;
      end
    end
    check_all(tag);
  endtask

  task automatic model_reset();
    model_q.delete();
    model_o   = '0;
    model_err = 1'b0;
  endtask

  initial begin
    // Reset held while an enabled push is requested: it must be discarded.
    Reset   = 1'b0;
    Enable  = 1'b1;
    PushPop = 1'b0;
    I       = 8'h55;
    model_reset();
    #1;
    check_all("rst_during0");
    @(posedge CLK);
    @(posedge CLK);
    #1;
    check_all("rst_during1");
    Enable = 1'b0;
    Reset  = 1'b1;
    #1;
    check_all("rst_after");

    // Three pushes, then an asynchronous reset mid-cycle.
    for (int k = 0; k < 3; k++) do_op(1'b1, 1'b0, 8'(8'h10 + k), "pre_rst_push");
    #2;
    Enable = 1'b0;
    Reset  = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    @(posedge CLK);
    #1;
    Reset = 1'b1;
    check_all("async_rst_rel");

    // Fill with 0..7, then an overflow push of 8.
    for (int k = 0; k < DEPTH; k++) do_op(1'b1, 1'b0, 8'(k), "fill");
    do_op(1'b1, 1'b0, 8'h08, "overflow");
    check("overflow_idle", 32'(Full), 32'(1));

    // Drain: expect 7..0.
    for (int k = 0; k < DEPTH; k++) begin
      do_op(1'b1, 1'b1, 8'h00, "drain");
      check("drain_val", 32'(O), 32'(DEPTH - 1 - k));
    end

    // Underflow pop holds O at 0.
    do_op(1'b1, 1'b1, 8'hEE, "underflow");
    do_op(1'b0, 1'b1, 8'hEE, "underflow_clr");

    // Fill again for the Enable=0 hold test.
    for (int k = 0; k < 4; k++) do_op(1'b1, 1'b0, 8'(8'hC0 + k), "refill");
    do_op(1'b1, 1'b1, 8'h00, "refill_pop");
    for (int k = 0; k < 5; k++) do_op(1'b0, 1'(k), 8'($urandom), "hold");
    while (model_q.size() > 0) do_op(1'b1, 1'b1, 8'h00, "empty_out");

    // Interleaved sequence.
    do_op(1'b1, 1'b0, 8'hA5, "il_push_a5");
    do_op(1'b1, 1'b0, 8'h3C, "il_push_3c");
    do_op(1'b1, 1'b1, 8'h00, "il_pop_3c");
    check("il_3c", 32'(O), 32'h3C);
    do_op(1'b1, 1'b0, 8'h77, "il_push_77");
    do_op(1'b1, 1'b1, 8'h00, "il_pop_77");
    check("il_77", 32'(O), 32'h77);
    do_op(1'b1, 1'b1, 8'h00, "il_pop_a5");
    check("il_a5", 32'(O), 32'hA5);
    check("il_empty", 32'(Empty), 32'(1));

    // Randomized operations; push bias drifts so both Full and Empty are hit.
    for (int n = 0; n < 400; n++) begin
      logic en_r;
      logic pp_r;
      en_r = ($urandom_range(0, 9) != 0);
      if ((n / 50) % 2 == 0) pp_r = ($urandom_range(0, 3) == 0);
      else pp_r = ($urandom_range(0, 3) != 0);
      do_op(en_r, pp_r, 8'($urandom), "rand");
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
